// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline
// Carries the decoded ID-stage control bundle through the ID/EX, EX/MEM and
// MEM/WB stages and delivers stage-aligned control to the EX, MEM and WB
// datapaths. It also detects load-use hazards (one bubble per pair), flushes
// the IF/ID register on a taken branch, and keeps saturating stall and flush
// event counters for performance debug.
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   id_*                   decoded control and register fields of the ID instr
//   ex_branch_taken        branch comparison result from the EX datapath
//   ex_*                   EX-stage control (registered)
//   mem_*                  MEM-stage control (registered)
//   wb_*                   WB-stage control (registered)
//   hazard_stall           freezes PC and IF/ID (combinational)
//   flush_ifid             squashes IF/ID (combinational)
//   stall_count            saturating count of stall cycles
//   flush_count            saturating count of taken-branch flushes
module ctrl_pipeline #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             id_valid,
  input  logic             id_ALUsrc,
  input  logic             id_MemtoReg,
  input  logic             id_RegWrite,
  input  logic             id_MemRead,
  input  logic             id_MemWrite,
  input  logic             id_Branch,
  input  logic [1:0]       id_ALUop,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,

  input  logic             ex_branch_taken,

  output logic             ex_valid,
  output logic             ex_ALUsrc,
  output logic             ex_Branch,
  output logic             ex_MemRead,
  output logic             ex_MemWrite,
  output logic             ex_RegWrite,
  output logic             ex_MemtoReg,
  output logic [1:0]       ex_ALUop,
  output logic [4:0]       ex_rd,

  output logic             mem_MemRead,
  output logic             mem_MemWrite,
  output logic             mem_RegWrite,
  output logic             mem_MemtoReg,
  output logic [4:0]       mem_rd,

  output logic             wb_RegWrite,
  output logic             wb_MemtoReg,
  output logic [4:0]       wb_rd,

  output logic             hazard_stall,
  output logic             flush_ifid,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // ID/EX stage register
  logic       ex_valid_q,    ex_valid_d;
  logic       ex_alusrc_q,   ex_alusrc_d;
  logic       ex_branch_q,   ex_branch_d;
  logic       ex_memread_q,  ex_memread_d;
  logic       ex_memwrite_q, ex_memwrite_d;
  logic       ex_regwrite_q, ex_regwrite_d;
  logic       ex_memtoreg_q, ex_memtoreg_d;
  logic [1:0] ex_aluop_q,    ex_aluop_d;
  logic [4:0] ex_rd_q,       ex_rd_d;

  // EX/MEM stage register
  logic       mem_memread_q,  mem_memread_d;
  logic       mem_memwrite_q, mem_memwrite_d;
  logic       mem_regwrite_q, mem_regwrite_d;
  logic       mem_memtoreg_q, mem_memtoreg_d;
  logic [4:0] mem_rd_q,       mem_rd_d;

  // MEM/WB stage register
  logic       wb_regwrite_q, wb_regwrite_d;
  logic       wb_memtoreg_q, wb_memtoreg_d;
  logic [4:0] wb_rd_q,       wb_rd_d;

  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic take;
  logic uses_rs2;
  logic raw;
  logic stall;
  logic id_regwrite_s;
  logic id_memtoreg_s;

  // Hazard and branch resolution
  always_comb begin
    take     = ex_valid_q & ex_branch_q & ex_branch_taken;
    uses_rs2 = ~id_ALUsrc | id_MemWrite;
    raw      = ex_valid_q & ex_memread_q & (ex_rd_q != 5'd0) & id_valid &
               ((ex_rd_q == id_rs1) | (uses_rs2 & (ex_rd_q == id_rs2)));
    // A taken branch discards the ID instruction, so its hazard is moot.
    stall    = raw & ~take;
  end

  // Writes to x0 are dropped, and MemtoReg is masked by the final RegWrite
  // so an undriven decoder MemtoReg never reaches the later stages.
  always_comb begin
    id_regwrite_s = id_RegWrite & (id_rd != 5'd0);
    id_memtoreg_s = id_regwrite_s & id_MemtoReg;
  end

  // ID/EX next state
  always_comb begin
    ex_valid_d    = 1'b0;
    ex_alusrc_d   = 1'b0;
    ex_branch_d   = 1'b0;
    ex_memread_d  = 1'b0;
    ex_memwrite_d = 1'b0;
    ex_regwrite_d = 1'b0;
    ex_memtoreg_d = 1'b0;
    ex_aluop_d    = 2'b00;
    ex_rd_d       = 5'd0;
    if (id_valid && !take && !stall) begin
      ex_valid_d    = 1'b1;
      ex_alusrc_d   = id_ALUsrc;
      ex_branch_d   = id_Branch;
      ex_memread_d  = id_MemRead;
      ex_memwrite_d = id_MemWrite;
      ex_regwrite_d = id_regwrite_s;
      ex_memtoreg_d = id_memtoreg_s;
      ex_aluop_d    = id_ALUop;
      ex_rd_d       = id_rd;
    end
  end

  // EX/MEM and MEM/WB advance every cycle; bubbles are already all-zero.
  always_comb begin
    mem_memread_d  = ex_memread_q;
    mem_memwrite_d = ex_memwrite_q;
    mem_regwrite_d = ex_regwrite_q;
    mem_memtoreg_d = ex_memtoreg_q;
    mem_rd_d       = ex_rd_q;

    wb_regwrite_d  = mem_regwrite_q;
    wb_memtoreg_d  = mem_memtoreg_q;
    wb_rd_d        = mem_rd_q;
  end

  // Saturating event counters
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_ONE;
    end
    if (take && (flush_count_q != CNT_MAX)) begin
      flush_count_d = flush_count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q     <= 1'b0;
      ex_alusrc_q    <= 1'b0;
      ex_branch_q    <= 1'b0;
      ex_memread_q   <= 1'b0;
      ex_memwrite_q  <= 1'b0;
      ex_regwrite_q  <= 1'b0;
      ex_memtoreg_q  <= 1'b0;
      ex_aluop_q     <= 2'b00;
      ex_rd_q        <= 5'd0;
      mem_memread_q  <= 1'b0;
      mem_memwrite_q <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_memtoreg_q <= 1'b0;
      mem_rd_q       <= 5'd0;
      wb_regwrite_q  <= 1'b0;
      wb_memtoreg_q  <= 1'b0;
      wb_rd_q        <= 5'd0;
      stall_count_q  <= '0;
      flush_count_q  <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_alusrc_q    <= ex_alusrc_d;
      ex_branch_q    <= ex_branch_d;
      ex_memread_q   <= ex_memread_d;
      ex_memwrite_q  <= ex_memwrite_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memtoreg_q  <= ex_memtoreg_d;
      ex_aluop_q     <= ex_aluop_d;
      ex_rd_q        <= ex_rd_d;
      mem_memread_q  <= mem_memread_d;
      mem_memwrite_q <= mem_memwrite_d;
      mem_regwrite_q <= mem_regwrite_d;
      mem_memtoreg_q <= mem_memtoreg_d;
      mem_rd_q       <= mem_rd_d;
      wb_regwrite_q  <= wb_regwrite_d;
      wb_memtoreg_q  <= wb_memtoreg_d;
      wb_rd_q        <= wb_rd_d;
      stall_count_q  <= stall_count_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_ALUsrc    = ex_alusrc_q;
  assign ex_Branch    = ex_branch_q;
  assign ex_MemRead   = ex_memread_q;
  assign ex_MemWrite  = ex_memwrite_q;
  assign ex_RegWrite  = ex_regwrite_q;
  assign ex_MemtoReg  = ex_memtoreg_q;
  assign ex_ALUop     = ex_aluop_q;
  assign ex_rd        = ex_rd_q;

  assign mem_MemRead  = mem_memread_q;
  assign mem_MemWrite = mem_memwrite_q;
  assign mem_RegWrite = mem_regwrite_q;
  assign mem_MemtoReg = mem_memtoreg_q;
  assign mem_rd       = mem_rd_q;

  assign wb_RegWrite  = wb_regwrite_q;
  assign wb_MemtoReg  = wb_memtoreg_q;
  assign wb_rd        = wb_rd_q;

  assign hazard_stall = stall;
  assign flush_ifid   = take;
  assign stall_count  = stall_count_q;
  assign flush_count  = flush_count_q;

endmodule
